isp_report_scheduler: RTL and testbench

Frame-synchronous scheduler between the ISP recognition datapath and the UART byte transmitter. At each frame start it snapshots the previous frame's recognition result (class, area, centroid) and sequences a fixed-format packet one byte at a time over a valid/ready handshake. It applies a report-rate divider and an enable, and counts reports lost because the previous packet was still in flight. It sits at the ISP output, upstream of the serializer that drives `uart_tx`.

---
 rtl/isp_report_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_isp_report_scheduler.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/isp_report_scheduler.sv
// rtl/isp_report_scheduler.sv - frame-synchronous recognition report packetizer feeding the UART byte transmitter
// Optional feature macro: ISP_REPORT_CHECKSUM_EN (appends a mod-256 checksum byte over bytes 2..9)
module isp_report_scheduler #(
  parameter int unsigned REPORT_DIV = 1,
  parameter logic [7:0]  HDR0       = 8'h55,
  parameter logic [7:0]  HDR1       = 8'hAA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_vsync,
  input  logic        report_en,
  input  logic        res_valid,
  input  logic [3:0]  res_class,
  input  logic [23:0] res_area,
  input  logic [11:0] res_cx,
  input  logic [11:0] res_cy,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        pkt_done,
  output logic [7:0]  drop_cnt
);

`ifdef ISP_REPORT_CHECKSUM_EN
  localparam logic [3:0] LAST_IDX = 4'd10;
`else
  localparam logic [3:0] LAST_IDX = 4'd9;
`endif

  localparam logic [7:0] DIV_LAST = 8'(REPORT_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic        vs_q;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic        req_q, req_d;
  logic [7:0]  drop_q, drop_d;
  logic [7:0]  class_q;
  logic [23:0] area_q;
  logic [11:0] cx_q;
  logic [11:0] cy_q;
  logic        load;
  logic        frame_edge;

  // Rising edge of vsync marks the start of a new frame.
  assign frame_edge = i_vsync & ~vs_q;

  // Frame divider and request qualification; the divider keeps counting even while a packet is in flight.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    req_d       = 1'b0;
    if (frame_edge) begin
      req_d       = (frame_cnt_q == 8'd0) & report_en;
      frame_cnt_d = (frame_cnt_q == DIV_LAST) ? 8'd0 : frame_cnt_q + 8'd1;
    end
  end

  // Edge detector, divider and one-cycle registered request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_q        <= 1'b0;
      frame_cnt_q <= 8'd0;
      req_q       <= 1'b0;
    end else begin
      vs_q        <= i_vsync;
      frame_cnt_q <= frame_cnt_d;
      req_q       <= req_d;
    end
  end

  // Packet sequencer: next state, byte index, handshake and done pulse.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    load     = 1'b0;
    tx_valid = 1'b0;
    pkt_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_q) begin
          state_d = ST_SEND;
          idx_d   = 4'd0;
          load    = 1'b1;
        end
      end
      ST_SEND: begin
        tx_valid = 1'b1;
        if (tx_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      ST_DONE: begin
        pkt_done = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A request that finds the sequencer outside IDLE (SEND or DONE) is lost and counted, saturating at 255.
  always_comb begin
    drop_d = drop_q;
    if (req_q && (state_q != ST_IDLE) && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  // Sequencer state, index and drop counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= 4'd0;
      drop_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      drop_q  <= drop_d;
    end
  end

  // Snapshot of the finished frame's result, taken only when a packet starts; invalid results read as class FF, zeros elsewhere.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      class_q <= 8'd0;
      area_q  <= 24'd0;
      cx_q    <= 12'd0;
      cy_q    <= 12'd0;
    end else if (load) begin
      if (res_valid) begin
        class_q <= {4'h0, res_class};
        area_q  <= res_area;
        cx_q    <= res_cx;
        cy_q    <= res_cy;
      end else begin
        class_q <= 8'hFF;
        area_q  <= 24'd0;
        cx_q    <= 12'd0;
        cy_q    <= 12'd0;
      end
    end
  end

`ifdef ISP_REPORT_CHECKSUM_EN
  logic [7:0] csum;
  assign csum = class_q + area_q[23:16] + area_q[15:8] + area_q[7:0]
              + {4'h0, cx_q[11:8]} + cx_q[7:0] + {4'h0, cy_q[11:8]} + cy_q[7:0];
`endif

  // Byte selection by index; the bus reads zero whenever no byte is offered.
  always_comb begin
    tx_data = 8'd0;
    if (state_q == ST_SEND) begin
      case (idx_q)
        4'd0:    tx_data = HDR0;
        4'd1:    tx_data = HDR1;
        4'd2:    tx_data = class_q;
        4'd3:    tx_data = area_q[23:16];
        4'd4:    tx_data = area_q[15:8];
        4'd5:    tx_data = area_q[7:0];
        4'd6:    tx_data = {4'h0, cx_q[11:8]};
        4'd7:    tx_data = cx_q[7:0];
        4'd8:    tx_data = {4'h0, cy_q[11:8]};
        4'd9:    tx_data = cy_q[7:0];
`ifdef ISP_REPORT_CHECKSUM_EN
        4'd10:   tx_data = csum;
`endif
        default: tx_data = 8'd0;
      endcase
    end
  end

  assign busy     = (state_q == ST_SEND);
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_isp_report_scheduler.sv
// tb/tb_isp_report_scheduler.sv - directed self-checking bench for isp_report_scheduler
module tb_isp_report_scheduler;

`ifdef ISP_REPORT_CHECKSUM_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_vsync = 1'b0;
  logic        report_en = 1'b1;
  logic        res_valid = 1'b1;
  logic [3:0]  res_class = 4'd0;
  logic [23:0] res_area = 24'd0;
  logic [11:0] res_cx = 12'd0;
  logic [11:0] res_cy = 12'd0;
  logic        tx_ready1 = 1'b1;
  logic        tx_ready3 = 1'b1;
  logic [7:0]  tx_data1, tx_data3;
  logic        tx_valid1, tx_valid3;
  logic        busy1, busy3;
  logic        pkt_done1, pkt_done3;
  logic [7:0]  drop1, drop3;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  bit          bp_mode = 1'b0;
  int          pd1 = 0;
  int          pd3 = 0;
  logic [7:0]  cap1[$];
  logic [7:0]  exp_b[0:10];
  bit          prev_stall = 1'b0;
  logic [7:0]  prev_data = 8'd0;

  always #5 clk = ~clk;

  isp_report_scheduler #(.REPORT_DIV(1)) u_div1 (
    .clk(clk), .rst(rst), .i_vsync(i_vsync), .report_en(report_en),
    .res_valid(res_valid), .res_class(res_class), .res_area(res_area),
    .res_cx(res_cx), .res_cy(res_cy),
    .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
    .busy(busy1), .pkt_done(pkt_done1), .drop_cnt(drop1)
  );

  isp_report_scheduler #(.REPORT_DIV(3)) u_div3 (
    .clk(clk), .rst(rst), .i_vsync(i_vsync), .report_en(report_en),
    .res_valid(res_valid), .res_class(res_class), .res_area(res_area),
    .res_cx(res_cx), .res_cy(res_cy),
    .tx_data(tx_data3), .tx_valid(tx_valid3), .tx_ready(tx_ready3),
    .busy(busy3), .pkt_done(pkt_done3), .drop_cnt(drop3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Byte monitor, done-pulse counters and hold-under-backpressure checks, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", {31'd0, tx_valid1}, 32'd1);
        chk("hold_data", {24'd0, tx_data1}, {24'd0, prev_data});
      end
      if (tx_valid1 && tx_ready1) cap1.push_back(tx_data1);
      if (pkt_done1) pd1++;
      if (pkt_done3) pd3++;
      prev_stall <= tx_valid1 && !tx_ready1;
      prev_data  <= tx_data1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (bp_mode) tx_ready1 = ((cyc / 3) % 2) == 0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse();
    i_vsync = 1'b1;
    tick();
    i_vsync = 1'b0;
    tick();
  endtask

  task automatic build_exp(input logic v, input logic [3:0] c, input logic [23:0] a,
                           input logic [11:0] x, input logic [11:0] y);
    logic [7:0] s;
    exp_b[0] = 8'h55;
    exp_b[1] = 8'hAA;
    exp_b[2] = v ? {4'h0, c} : 8'hFF;
    exp_b[3] = v ? a[23:16] : 8'h00;
    exp_b[4] = v ? a[15:8] : 8'h00;
    exp_b[5] = v ? a[7:0] : 8'h00;
    exp_b[6] = v ? {4'h0, x[11:8]} : 8'h00;
    exp_b[7] = v ? x[7:0] : 8'h00;
    exp_b[8] = v ? {4'h0, y[11:8]} : 8'h00;
    exp_b[9] = v ? y[7:0] : 8'h00;
    s = 8'h00;
    for (int i = 2; i < 10; i++) s = s + exp_b[i];
    exp_b[10] = s;
  endtask

  task automatic cmp_packet(input string tag, input int base);
    chk({tag, "_len"}, cap1.size() - base, NB);
    for (int i = 0; i < NB; i++) begin
      if (base + i < cap1.size()) chk({tag, "_byte"}, {24'd0, cap1[base + i]}, {24'd0, exp_b[i]});
      else chk({tag, "_missing"}, 32'hFFFF_FFFF, {24'd0, exp_b[i]});
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ticks(2);
    rst = 1'b0;
    tick();
  endtask

  initial begin
    int base;
    int pbase;

    ticks(2);
    chk("rst_tx_data", {24'd0, tx_data1}, 32'd0);
    chk("rst_tx_valid", {31'd0, tx_valid1}, 32'd0);
    chk("rst_busy", {31'd0, busy1}, 32'd0);
    chk("rst_pkt_done", {31'd0, pkt_done1}, 32'd0);
    chk("rst_drop", {24'd0, drop1}, 32'd0);
    chk("rst_valid3", {31'd0, tx_valid3}, 32'd0);
    rst = 1'b0;
    ticks(2);

    // Basic packet with exact one-cycle request latency.
    res_valid = 1'b1; res_class = 4'd3; res_area = 24'h012345; res_cx = 12'h321; res_cy = 12'h1A0;
    build_exp(1'b1, 4'd3, 24'h012345, 12'h321, 12'h1A0);
    base = cap1.size();
    pbase = pd1;
    i_vsync = 1'b1;
    tick();
    chk("lat_k_valid", {31'd0, tx_valid1}, 32'd0);
    i_vsync = 1'b0;
    tick();
    chk("lat_k1_valid", {31'd0, tx_valid1}, 32'd1);
    chk("lat_k1_data", {24'd0, tx_data1}, 32'h55);
    chk("lat_k1_busy", {31'd0, busy1}, 32'd1);
    ticks(14);
    cmp_packet("basic", base);
    chk("basic_done", pd1 - pbase, 32'd1);
    chk("basic_idle", {31'd0, busy1}, 32'd0);

    // Backpressure: ready toggles every three cycles.
    res_class = 4'd9; res_area = 24'hABCDEF; res_cx = 12'hFED; res_cy = 12'h00F;
    build_exp(1'b1, 4'd9, 24'hABCDEF, 12'hFED, 12'h00F);
    base = cap1.size();
    pbase = pd1;
    bp_mode = 1'b1;
    pulse();
    ticks(40);
    bp_mode = 1'b0;
    tx_ready1 = 1'b1;
    tick();
    cmp_packet("bp", base);
    chk("bp_done", pd1 - pbase, 32'd1);

    // Invalid result reads as class FF with zero payload.
    res_valid = 1'b0; res_class = 4'd7; res_area = 24'h777777; res_cx = 12'h777; res_cy = 12'h777;
    build_exp(1'b0, 4'd7, 24'h777777, 12'h777, 12'h777);
    base = cap1.size();
    pulse();
    ticks(14);
    cmp_packet("inval", base);

    // Reset asserted after four bytes; the next frame starts a fresh packet.
    res_valid = 1'b1; res_class = 4'd5; res_area = 24'h00FF10; res_cx = 12'h0AB; res_cy = 12'hC0D;
    build_exp(1'b1, 4'd5, 24'h00FF10, 12'h0AB, 12'hC0D);
    base = cap1.size();
    pulse();
    ticks(4);
    chk("mid_bytes", cap1.size() - base, 32'd4);
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, tx_valid1}, 32'd0);
    chk("arst_data", {24'd0, tx_data1}, 32'd0);
    chk("arst_busy", {31'd0, busy1}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    base = cap1.size();
    pulse();
    chk("fresh_hdr", {24'd0, tx_data1}, 32'h55);
    ticks(14);
    cmp_packet("fresh", base);

    // Divider of three: pulses 1, 4, 7 report.
    do_reset();
    pbase = pd3;
    for (int p = 1; p <= 7; p++) begin
      pulse();
      ticks(14);
    end
    chk("div_pkts", pd3 - pbase, 32'd3);
    chk("div_drop", {24'd0, drop3}, 32'd0);

    // Same with the enable low at pulse 4 only.
    do_reset();
    pbase = pd3;
    for (int p = 1; p <= 7; p++) begin
      report_en = (p != 4);
      pulse();
      report_en = 1'b1;
      ticks(14);
    end
    chk("en_pkts", pd3 - pbase, 32'd2);
    chk("en_drop", {24'd0, drop3}, 32'd0);

    // Permanent stall: drops saturate and byte 0 is held.
    do_reset();
    tx_ready1 = 1'b0;
    tx_ready3 = 1'b0;
    pulse();
    pulse();
    chk("drop_first", {24'd0, drop1}, 32'd1);
    for (int p = 0; p < 298; p++) pulse();
    chk("drop_sat", {24'd0, drop1}, 32'd255);
    chk("sat_busy", {31'd0, busy1}, 32'd1);
    chk("sat_valid", {31'd0, tx_valid1}, 32'd1);
    chk("sat_data", {24'd0, tx_data1}, 32'h55);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
